// File: rtl/mem320_frame_writer.sv
// ---------------------------------------------------------------------------
// mem320_frame_writer
//
// Purpose:
//   This is the writer side of the two-bank 320x320 pixel store.
//   - It accepts one raster-order source frame (SRC_W x SRC_H, DATA_W bits
//     per pixel).
//   - It decimates the frame 2:1 in both axes. A pixel is kept only when
//     both its row and its column are even.
//   - Each kept pixel goes to one of two banks by its linear destination
//     index:
//       * indices below BANK_DEPTH are written to bank 0;
//       * the rest are written to bank 1 at (index - BANK_DEPTH).
//   - A one-cycle done320 pulse marks a completed frame. The reader side
//     uses it as its load trigger.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   single-cycle pulse, starts a frame from IDLE
//   in_valid  in   source pixel valid
//   in_pixel  in   source pixel [DATA_W]
//   in_ready  out  writer accepts pixels (RUN only)
//   wr_en0    out  bank 0 write strobe
//   wr_en1    out  bank 1 write strobe
//   wr_addr   out  bank-local write address [BANK_AW]
//   wr_data   out  write data [DATA_W]
//   busy      out  high while a frame is being received
//   done320   out  one-cycle frame-complete pulse
// ---------------------------------------------------------------------------
module mem320_frame_writer #(
  parameter int SRC_W      = 640,
  parameter int SRC_H      = 640,
  parameter int BANK_DEPTH = 51200,
  parameter int DATA_W     = 8,
  parameter int BANK_AW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_pixel,
  output logic               in_ready,
  output logic               wr_en0,
  output logic               wr_en1,
  output logic [BANK_AW-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done320
);

  localparam int COL_W  = (SRC_W > 2) ? $clog2(SRC_W) : 1;
  localparam int ROW_W  = (SRC_H > 2) ? $clog2(SRC_H) : 1;
  // dest must also hold the one-past-the-end value reached after the final write
  localparam int DEST_W = $clog2((SRC_W / 2) * (SRC_H / 2) + 1);
  localparam int EXT_W  = (DEST_W > BANK_AW) ? DEST_W : BANK_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [COL_W-1:0]    r_col_p0;
  logic [ROW_W-1:0]    r_row_p0;
  logic [DEST_W-1:0]   r_dest_p0;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_wr_en0_p1;
  logic                r_wr_en1_p1;
  logic [BANK_AW-1:0]  r_wr_addr_p1;
  logic [DATA_W-1:0]   r_wr_data_p1;

  logic                w_accept;
  logic                w_keep;
  logic                w_col_last;
  logic                w_row_last;
  logic [EXT_W-1:0]    w_dest_ext;
  logic                w_in_bank1;
  logic [BANK_AW-1:0]  w_local_addr;

  // Bank-local address for a destination index. The subtraction is done at
  // a width that fits both the dest counter and the bank address, so that
  // small bank depths and narrow counters both map cleanly.
  function automatic logic [BANK_AW-1:0] bank_local(input logic [EXT_W-1:0] d,
                                                    input logic            hi);
    logic [EXT_W-1:0] v;
    v = hi ? (d - EXT_W'(BANK_DEPTH)) : d;
    return BANK_AW'(v);
  endfunction

  // ---- stage p0: accept, keep decision, raster counters ----
  // in_ready is a registered copy of "state is RUN", so an accept is just
  // valid qualified by it.
  assign w_accept     = in_valid && r_in_ready;
  // Keep even row / even column only.
  assign w_keep       = w_accept && !r_col_p0[0] && !r_row_p0[0];
  assign w_col_last   = (r_col_p0 == COL_W'(SRC_W - 1));
  assign w_row_last   = (r_row_p0 == ROW_W'(SRC_H - 1));
  assign w_dest_ext   = EXT_W'(r_dest_p0);
  assign w_in_bank1   = (w_dest_ext >= EXT_W'(BANK_DEPTH));
  assign w_local_addr = bank_local(w_dest_ext, w_in_bank1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col_p0     <= '0;
      r_row_p0     <= '0;
      r_dest_p0    <= '0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_en0_p1  <= 1'b0;
      r_wr_en1_p1  <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      // Strobes and done are single-cycle unless re-armed below.
      r_wr_en0_p1 <= 1'b0;
      r_wr_en1_p1 <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_col_p0   <= '0;
            r_row_p0   <= '0;
            r_dest_p0  <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          // ---- stage p1: write port register ----
          if (w_keep) begin
            r_wr_en0_p1  <= !w_in_bank1;
            r_wr_en1_p1  <= w_in_bank1;
            r_wr_addr_p1 <= w_local_addr;
            r_wr_data_p1 <= in_pixel;
            r_dest_p0    <= r_dest_p0 + 1'b1;
          end

          if (w_accept) begin
            if (w_col_last) begin
              r_col_p0 <= '0;
              if (w_row_last) begin
                // The final pixel is odd-indexed and produces no write, so
                // every write has already been issued by now.
                r_row_p0   <= '0;
                r_state    <= ST_DONE;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_row_p0 <= r_row_p0 + 1'b1;
              end
            end else begin
              r_col_p0 <= r_col_p0 + 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done320  = r_done;
  assign wr_en0   = r_wr_en0_p1;
  assign wr_en1   = r_wr_en1_p1;
  assign wr_addr  = r_wr_addr_p1;
  assign wr_data  = r_wr_data_p1;

endmodule

// File: tb/tb_mem320_frame_writer.sv
module tb_mem320_frame_writer;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int BD = 32;
  localparam int N  = W * H;
  localparam int NW = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = 8'd0;
  logic        in_ready;
  logic        wr_en0;
  logic        wr_en1;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done320;

  mem320_frame_writer #(
    .SRC_W(W), .SRC_H(H), .BANK_DEPTH(BD), .DATA_W(8), .BANK_AW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .wr_en0(wr_en0),
    .wr_en1(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done320(done320)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bank;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int mode;        // 0 continuous, 1 toggled valid, 2 random valid
    bit pattern;     // 1: pixel=(row+col)&0xFF, 0: random pixels
    int abort_at;    // reset after this many accepts (0 = none)
    int restart_at;  // pulse start at this accept count (0 = none)
    int exp_writes;
    int exp_done;
  } vec_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] pix[N];
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         last_acc_cyc = -1;
  int         both_cnt = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: record every write and every done pulse.
  always @(negedge clk) begin
    wr_t w;
    if (wr_en0 && wr_en1) both_cnt++;
    if (wr_en0 || wr_en1) begin
      w.bank = wr_en1;
      w.addr = wr_addr;
      w.data = wr_data;
      wr_q.push_back(w);
    end
    if (in_valid && in_ready) last_acc_cyc = cyc + 1;
    if (done320) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: fills the source frame and lists the writes it must produce.
  task automatic build_model(input bit pattern);
    wr_t w;
    int  idx;
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        pix[r*W+c] = pattern ? 8'((r + c) & 255) : 8'($urandom);
        if ((r % 2 == 0) && (c % 2 == 0)) begin
          idx    = (r / 2) * (W / 2) + c / 2;
          w.bank = (idx >= BD);
          w.addr = 16'(idx % BD);
          w.data = pix[r*W+c];
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    int k;
    int budget;
    int bad;
    bit tog;
    bit acc;
    bit aborted;
    build_model(v.pattern);
    wr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; budget = 0; tog = 1'b1; aborted = 1'b0;
    while (k < N && budget < 8 * N) begin
      budget++;
      case (v.mode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = ~tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_pixel = pix[k];
      start = (v.restart_at > 0) && (k == v.restart_at);
      @(negedge clk);
      if (budget == 1) check(in_ready === 1'b1 && busy === 1'b1, "run_flags", {in_ready, busy}, 3);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      if (v.abort_at > 0 && k == v.abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check(aborted || k == N, "accepts", k, N);
    if (aborted) begin
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
      check({in_ready, wr_en0, wr_en1, wr_addr, wr_data, busy, done320} === '0,
            "abort_outputs", int'({in_ready, wr_en0, wr_en1, busy, done320}), 0);
      @(negedge clk); #1;
    end else begin
      @(negedge clk); #1;
      check(done320 === 1'b1 && in_ready === 1'b0 && busy === 1'b0, "done_flags",
            {done320, in_ready, busy}, 4);
      check(done_cyc == last_acc_cyc, "done_timing", done_cyc, last_acc_cyc);
    end
    check(wr_q.size() == v.exp_writes, "write_count", wr_q.size(), v.exp_writes);
    bad = -1;
    foreach (wr_q[i]) begin
      if (i >= exp_q.size() || wr_q[i] != exp_q[i]) begin
        bad = i;
        break;
      end
    end
    check(bad < 0, "write_seq_first_bad_index", bad, -1);
    check(done_cnt == v.exp_done, "done_count", done_cnt, v.exp_done);
  endtask

  vec_t tbl[5];

  initial begin
    int bad;
    tbl[0] = '{mode: 0, pattern: 1'b1, abort_at: 0,   restart_at: 0,   exp_writes: NW, exp_done: 1};
    tbl[1] = '{mode: 1, pattern: 1'b1, abort_at: 0,   restart_at: 0,   exp_writes: NW, exp_done: 1};
    tbl[2] = '{mode: 2, pattern: 1'b0, abort_at: 0,   restart_at: 0,   exp_writes: NW, exp_done: 1};
    tbl[3] = '{mode: 0, pattern: 1'b0, abort_at: 100, restart_at: 0,   exp_writes: 26, exp_done: 0};
    tbl[4] = '{mode: 0, pattern: 1'b0, abort_at: 0,   restart_at: 100, exp_writes: NW, exp_done: 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({in_ready, wr_en0, wr_en1, wr_addr, wr_data, busy, done320} === '0,
          "reset_outputs", int'({in_ready, wr_en0, wr_en1, busy, done320}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // IDLE ignores in_valid without start
    in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || wr_en0 !== 1'b0 || wr_en1 !== 1'b0 || busy !== 1'b0) bad++;
    end
    check(bad == 0, "idle_ignore", bad, 0);
    check(wr_q.size() == 0, "idle_no_writes", wr_q.size(), 0);
    @(posedge clk); #1 in_valid = 1'b0;

    // Frames run back-to-back: each start lands on the cycle after done320.
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i]);
      if (i == 0) begin
        if (wr_q.size() == NW) begin
          check(wr_q[0].bank == 1'b0 && wr_q[0].addr == 16'd0 && wr_q[0].data == 8'd0,
                "first_write", int'(wr_q[0]), 0);
          check(wr_q[BD-1].bank == 1'b0 && wr_q[BD].bank == 1'b1 && wr_q[BD].addr == 16'd0
                && wr_q[BD].data == 8'd8, "first_bank1_write", int'(wr_q[BD]), int'({1'b1, 16'd0, 8'd8}));
          check(wr_q[NW-1].bank == 1'b1 && wr_q[NW-1].addr == 16'(BD-1) && wr_q[NW-1].data == 8'd28,
                "last_write", int'(wr_q[NW-1]), int'({1'b1, 16'(BD-1), 8'd28}));
        end else begin
          check(1'b0, "pattern_frame_size", wr_q.size(), NW);
        end
      end
    end

    check(both_cnt == 0, "strobe_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
